lin_comm_frame: RTL and testbench

Parametrised LIN commander frame transmitter, the next generation of the header-only commander. It sends break, delimiter, sync and protected identifier (PID) with a configurable break length and bit period. It can also publish a commander response: 1..MAX_BYTES data bytes followed by a classic or enhanced checksum. It sits between the scheduler, which supplies start, pid and payload, and the LIN line driver on sdo_comm.

---
 rtl/lin_comm_frame.sv | 212 +++++++++++++++++++++
 tb/tb_lin_comm_frame.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lin_comm_frame.sv
// LIN commander frame transmitter: break, delimiter, sync and protected identifier,
// optionally followed by a commander response with a classic or enhanced checksum.
module lin_comm_frame #(
    parameter int BREAK_BITS = 13,
    parameter int CLK_DIV    = 1,
    parameter int MAX_BYTES  = 8,
    parameter int HDR_W      = BREAK_BITS + 21,
    parameter int LW         = $clog2(MAX_BYTES + 1)
) (
    input  logic                   sys_clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [5:0]             pid,
    input  logic                   tx_resp,
    input  logic [LW-1:0]          data_len,
    input  logic                   enh_csum,
    input  logic [8*MAX_BYTES-1:0] data_in,
    input  logic                   inter_tx_delay,
    input  logic                   resp_busy,
    output logic                   sdo_comm,
    output logic                   lin_busy,
    output logic                   hdr_valid,
    output logic [HDR_W-1:0]       frame_header_out,
    output logic                   comm_tx_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_BREAK, S_DELIM, S_SYNC, S_PID, S_DATA, S_CSUM, S_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [4:0]             bit_q, bit_d;
    logic [LW-1:0]          bytes_q, bytes_d;
    logic [8*MAX_BYTES-1:0] data_q, data_d;
    logic [7:0]             sum_q, sum_d;
    logic [5:0]             pid_q, pid_d;
    logic                   resp_q, resp_d;
    logic                   enh_q, enh_d;
    logic [HDR_W-1:0]       hdr_q, hdr_d;
    logic                   hdr_valid_q, hdr_valid_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic                   in_frame;
    logic                   in_header;
    logic                   bit_end;
    logic                   last_bit;
    logic                   field_end;
    logic [LW-1:0]          eff_len;
    logic [7:0]             pid_byte;
    logic [7:0]             tx_byte;
    logic [15:0]            frame_word;
    logic                   tx_bit;
    logic [8:0]             sum_t;
    logic [7:0]             sum_fold;

    assign accept    = (state_q == S_IDLE) && start && !inter_tx_delay && !resp_busy;
    assign in_frame  = (state_q != S_IDLE) && (state_q != S_WAIT);
    assign in_header = (state_q == S_BREAK) || (state_q == S_DELIM) ||
                       (state_q == S_SYNC)  || (state_q == S_PID);
    assign bit_end   = (div_q == DIV_W'(CLK_DIV - 1));
    assign field_end = in_frame && bit_end && last_bit;
    assign eff_len   = (data_len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : data_len;

    assign pid_byte  = {~(pid_q[1] ^ pid_q[3] ^ pid_q[4] ^ pid_q[5]),
                        pid_q[0] ^ pid_q[1] ^ pid_q[2] ^ pid_q[4],
                        pid_q};

    // End-around-carry add of the current data byte into the running checksum.
    assign sum_t    = {1'b0, sum_q} + {1'b0, data_q[7:0]};
    assign sum_fold = sum_t[7:0] + {7'd0, sum_t[8]};

    always_comb begin
        last_bit = 1'b0;
        case (state_q)
            S_BREAK: last_bit = (bit_q == 5'(BREAK_BITS - 1));
            S_DELIM: last_bit = 1'b1;
            default: last_bit = (bit_q == 5'd9);
        endcase
    end

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            S_SYNC:  tx_byte = 8'h55;
            S_PID:   tx_byte = pid_byte;
            S_DATA:  tx_byte = data_q[7:0];
            S_CSUM:  tx_byte = ~sum_q;
            default: tx_byte = 8'h00;
        endcase
    end

    // Start bit at index 0, byte LSB-first, stop bit at index 9; upper fill unused.
    assign frame_word = {7'h7F, tx_byte, 1'b0};
    assign tx_bit     = frame_word[bit_q[3:0]];

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_BREAK;
            S_BREAK: if (field_end) state_d = S_DELIM;
            S_DELIM: if (field_end) state_d = S_SYNC;
            S_SYNC:  if (field_end) state_d = S_PID;
            S_PID:   if (field_end) state_d = (resp_q && (bytes_q != '0)) ? S_DATA : S_WAIT;
            S_DATA:  if (field_end && (bytes_q == LW'(1))) state_d = S_CSUM;
            S_CSUM:  if (field_end) state_d = S_WAIT;
            S_WAIT:  if (!resp_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sdo_comm = 1'b1;
        case (state_q)
            S_BREAK: sdo_comm = 1'b0;
            S_DELIM: sdo_comm = 1'b1;
            S_SYNC, S_PID, S_DATA, S_CSUM: sdo_comm = tx_bit;
            default: sdo_comm = 1'b1;
        endcase
        lin_busy         = in_frame;
        hdr_valid        = hdr_valid_q;
        frame_header_out = hdr_valid_q ? hdr_q : '0;
        comm_tx_done     = done_q;
    end

    always_comb begin
        div_d       = div_q;
        bit_d       = bit_q;
        bytes_d     = bytes_q;
        data_d      = data_q;
        sum_d       = sum_q;
        pid_d       = pid_q;
        resp_d      = resp_q;
        enh_d       = enh_q;
        hdr_d       = hdr_q;
        hdr_valid_d = hdr_valid_q;

        if (accept) begin
            pid_d       = pid;
            resp_d      = tx_resp;
            enh_d       = enh_csum;
            bytes_d     = eff_len;
            data_d      = data_in;
            sum_d       = '0;
            hdr_d       = '0;
            hdr_valid_d = 1'b0;
        end

        if (in_frame) begin
            div_d = bit_end ? '0 : div_q + DIV_W'(1);
            if (bit_end) begin
                bit_d = last_bit ? 5'd0 : bit_q + 5'd1;
            end
            if (bit_end && in_header) begin
                hdr_d = {hdr_q[HDR_W-2:0], sdo_comm};
            end
        end

        if (field_end && (state_q == S_PID)) begin
            hdr_valid_d = 1'b1;
            sum_d       = enh_q ? pid_byte : 8'h00;
        end

        if (field_end && (state_q == S_DATA)) begin
            sum_d   = sum_fold;
            data_d  = data_q >> 8;
            bytes_d = bytes_q - LW'(1);
        end
    end

    assign done_d = field_end && (state_d == S_WAIT);

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            div_q       <= '0;
            bit_q       <= '0;
            bytes_q     <= '0;
            data_q      <= '0;
            sum_q       <= '0;
            pid_q       <= '0;
            resp_q      <= 1'b0;
            enh_q       <= 1'b0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            div_q       <= div_d;
            bit_q       <= bit_d;
            bytes_q     <= bytes_d;
            data_q      <= data_d;
            sum_q       <= sum_d;
            pid_q       <= pid_d;
            resp_q      <= resp_d;
            enh_q       <= enh_d;
            hdr_q       <= hdr_d;
            hdr_valid_q <= hdr_valid_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_lin_comm_frame.sv
// Bench for lin_comm_frame: a reference model pushes expected frames into a scoreboard
// queue and a serial monitor pops and compares them bit by bit as the line is driven.
module tb_lin_comm_frame;

    localparam int LW = 4;
    localparam int HW = 34;

    logic        sys_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic [5:0]  pid = '0;
    logic        tx_resp = 1'b0;
    logic [LW-1:0] data_len = '0;
    logic        enh_csum = 1'b0;
    logic [63:0] data_in = '0;
    logic        inter_tx_delay = 1'b0;
    logic        resp_busy = 1'b0;

    logic          sdo_comm, lin_busy, hdr_valid, comm_tx_done;
    logic [HW-1:0] frame_header_out;
    logic          sdo_comm4, lin_busy4, hdr_valid4, comm_tx_done4;
    logic [HW-1:0] frame_header_out4;

    always #5 sys_clk = ~sys_clk;

    lin_comm_frame u_dut (
        .sys_clk(sys_clk), .rstn(rstn), .start(start), .pid(pid), .tx_resp(tx_resp),
        .data_len(data_len), .enh_csum(enh_csum), .data_in(data_in),
        .inter_tx_delay(inter_tx_delay), .resp_busy(resp_busy),
        .sdo_comm(sdo_comm), .lin_busy(lin_busy), .hdr_valid(hdr_valid),
        .frame_header_out(frame_header_out), .comm_tx_done(comm_tx_done)
    );

    lin_comm_frame #(.CLK_DIV(4)) u_dut4 (
        .sys_clk(sys_clk), .rstn(rstn), .start(start4), .pid(pid), .tx_resp(tx_resp),
        .data_len(data_len), .enh_csum(enh_csum), .data_in(data_in),
        .inter_tx_delay(inter_tx_delay), .resp_busy(resp_busy),
        .sdo_comm(sdo_comm4), .lin_busy(lin_busy4), .hdr_valid(hdr_valid4),
        .frame_header_out(frame_header_out4), .comm_tx_done(comm_tx_done4)
    );

    typedef struct packed {
        logic [127:0]  bits;
        logic [31:0]   n;
        logic [HW-1:0] hdr;
    } frame_t;

    frame_t       sb_q[$];
    int           checks = 0;
    int           errors = 0;
    int           frames_done = 0;
    logic [127:0] rx_bits = '0;
    int           rx_n = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // Reference model: bit 0 of .bits is the first bit on the line.
    function automatic frame_t build_frame(input logic [5:0] id, input bit resp, input int dlen,
                                           input bit enh, input logic [63:0] d);
        frame_t     f;
        logic [7:0] pb, s, b;
        logic [8:0] t;
        int         n, eff;
        f  = '0;
        n  = 0;
        pb = {~(id[1] ^ id[3] ^ id[4] ^ id[5]), id[0] ^ id[1] ^ id[2] ^ id[4], id};
        for (int i = 0; i < 13; i++) begin
            f.bits[n] = 1'b0;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        f.bits[n +: 10] = {1'b1, 8'h55, 1'b0};
        n += 10;
        f.bits[n +: 10] = {1'b1, pb, 1'b0};
        n += 10;
        for (int i = 0; i < HW; i++) f.hdr[HW-1-i] = f.bits[i];
        eff = (dlen > 8) ? 8 : dlen;
        if (resp && eff > 0) begin
            s = enh ? pb : 8'h00;
            for (int k = 0; k < eff; k++) begin
                b = d[8*k +: 8];
                f.bits[n +: 10] = {1'b1, b, 1'b0};
                n += 10;
                t = {1'b0, s} + {1'b0, b};
                s = t[7:0] + {7'd0, t[8]};
            end
            f.bits[n +: 10] = {1'b1, ~s, 1'b0};
            n += 10;
        end
        f.n = 32'(n);
        return f;
    endfunction

    function automatic logic [7:0] rx_csum();
        logic [7:0] cs;
        for (int j = 0; j < 8; j++) cs[j] = rx_bits[rx_n - 9 + j];
        return cs;
    endfunction

    task automatic send(input logic [5:0] p, input bit r, input int len, input bit e,
                        input logic [63:0] d);
        pid      = p;
        tx_resp  = r;
        data_len = LW'(len);
        enh_csum = e;
        data_in  = d;
        sb_q.push_back(build_frame(p, r, len, e, d));
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string tag);
        int t;
        t = 0;
        while (frames_done < target && t < 3000) begin
            tick;
            t++;
        end
        check(tag, 128'(frames_done >= target), 128'(1));
    endtask

    // Serial monitor: pops the expected frame when lin_busy rises, checks every bit.
    initial begin : monitor
        frame_t cur;
        bit     in_fr;
        bit     have;
        int     cnt;
        cur   = '0;
        in_fr = 1'b0;
        have  = 1'b0;
        cnt   = 0;
        forever begin
            @(negedge sys_clk);
            if (!rstn) begin
                in_fr = 1'b0;
            end else begin
                if (lin_busy && !in_fr) begin
                    in_fr   = 1'b1;
                    cnt     = 0;
                    rx_bits = '0;
                    have    = (sb_q.size() > 0);
                    if (have) cur = sb_q.pop_front();
                    check("frame_expected", 128'(have), 128'(1));
                end
                if (in_fr && lin_busy) begin
                    if (have && cnt < 128) check("sdo_bit", 128'(sdo_comm), 128'(cur.bits[cnt]));
                    if (cnt < 128) rx_bits[cnt] = sdo_comm;
                    cnt++;
                end else if (in_fr) begin
                    check("frame_len", 128'(cnt), 128'(cur.n));
                    check("done_pulse", 128'(comm_tx_done), 128'(1));
                    check("hdr_valid_end", 128'(hdr_valid), 128'(1));
                    check("header", 128'(frame_header_out), 128'(cur.hdr));
                    rx_n  = cnt;
                    in_fr = 1'b0;
                    frames_done++;
                end else begin
                    check("done_idle", 128'(comm_tx_done), 128'(0));
                end
            end
        end
    end

    initial begin : stim
        frame_t f;
        int     nf;
        int     cnt;
        nf = 0;

        repeat (3) tick;
        check("rst_sdo", 128'(sdo_comm), 128'(1));
        check("rst_busy", 128'(lin_busy), 128'(0));
        check("rst_hdr_valid", 128'(hdr_valid), 128'(0));
        check("rst_header", 128'(frame_header_out), 128'(0));
        check("rst_done", 128'(comm_tx_done), 128'(0));
        check("rst_sdo4", 128'(sdo_comm4), 128'(1));
        check("rst_busy4", 128'(lin_busy4), 128'(0));
        rstn = 1'b1;
        tick;

        // Header only; start held during the frame must not trigger another one.
        send(6'h3C, 1'b0, 0, 1'b0, 64'h0);
        check("busy_after_accept", 128'(lin_busy), 128'(1));
        check("sdo_first_break", 128'(sdo_comm), 128'(0));
        start = 1'b1;
        repeat (5) tick;
        start = 1'b0;
        nf++;
        wait_frames(nf, "wait_hdr_only");
        check("sdo_idle_after", 128'(sdo_comm), 128'(1));
        check("hdr_hold_idle", 128'(hdr_valid), 128'(1));
        $display("frame hdr-only pid=3C header=%0h", frame_header_out);

        // Enhanced then classic checksum over 0x01, 0x02.
        send(6'h3C, 1'b1, 2, 1'b1, 64'h0201);
        nf++;
        wait_frames(nf, "wait_enh");
        f = build_frame(6'h3C, 1'b1, 2, 1'b1, 64'h0201);
        check("len64_enh", 128'(rx_n), 128'(64));
        check("csum_enh", 128'(rx_csum()), 128'(f.bits[f.n-9 +: 8]));
        $display("frame enh data=01,02 csum=%0h", rx_csum());
        tick;

        send(6'h3C, 1'b1, 2, 1'b0, 64'h0201);
        nf++;
        wait_frames(nf, "wait_classic");
        check("len64_classic", 128'(rx_n), 128'(64));
        check("csum_classic", 128'(rx_csum()), 128'(8'hFC));
        $display("frame classic data=01,02 csum=%0h", rx_csum());
        tick;

        send(6'h10, 1'b1, 2, 1'b0, 64'h02FF);
        nf++;
        wait_frames(nf, "wait_carry");
        check("csum_carry", 128'(rx_csum()), 128'(8'hFD));
        $display("frame classic data=FF,02 csum=%0h", rx_csum());
        tick;

        // data_len beyond MAX_BYTES clamps to 8 bytes.
        send(6'h2A, 1'b1, 9, 1'b0, {$urandom, $urandom});
        nf++;
        wait_frames(nf, "wait_len9");
        check("len_clamped", 128'(rx_n), 128'(124));
        $display("frame len=9 clamped bits=%0d", rx_n);
        tick;

        send(6'h15, 1'b1, 5, 1'b1, {$urandom, $urandom});
        nf++;
        wait_frames(nf, "wait_enh5");
        $display("frame enh len=5 bits=%0d", rx_n);
        tick;

        // Inhibits: neither inter_tx_delay nor resp_busy may let a frame start.
        inter_tx_delay = 1'b1;
        start = 1'b1;
        repeat (4) begin
            tick;
            check("inhibit_itd", 128'(lin_busy), 128'(0));
        end
        resp_busy = 1'b1;
        inter_tx_delay = 1'b0;
        repeat (4) begin
            tick;
            check("inhibit_resp_busy", 128'(lin_busy), 128'(0));
        end
        start = 1'b0;
        resp_busy = 1'b0;
        tick;
        $display("inhibit test done");

        // resp_busy held after the frame keeps the commander in WAIT.
        send(6'h01, 1'b0, 0, 1'b0, 64'h0);
        resp_busy = 1'b1;
        nf++;
        wait_frames(nf, "wait_hold");
        pid = 6'h07;
        start = 1'b1;
        repeat (6) begin
            tick;
            check("wait_no_restart", 128'(lin_busy), 128'(0));
            check("wait_sdo_high", 128'(sdo_comm), 128'(1));
        end
        sb_q.push_back(build_frame(6'h07, 1'b0, 0, 1'b0, 64'h0));
        resp_busy = 1'b0;
        tick;
        check("release_to_idle", 128'(lin_busy), 128'(0));
        tick;
        check("restart_after_release", 128'(lin_busy), 128'(1));
        start = 1'b0;
        nf++;
        wait_frames(nf, "wait_restart");
        $display("frame after resp_busy release pid=07");
        tick;

        // Asynchronous reset in the middle of the response.
        send(6'h22, 1'b1, 4, 1'b1, {$urandom, $urandom});
        repeat (45) tick;
        check("busy_before_rst", 128'(lin_busy), 128'(1));
        #2;
        rstn = 1'b0;
        #1;
        check("arst_sdo", 128'(sdo_comm), 128'(1));
        check("arst_busy", 128'(lin_busy), 128'(0));
        check("arst_hdr_valid", 128'(hdr_valid), 128'(0));
        check("arst_header", 128'(frame_header_out), 128'(0));
        check("arst_done", 128'(comm_tx_done), 128'(0));
        repeat (3) tick;
        rstn = 1'b1;
        tick;
        send(6'h22, 1'b1, 3, 1'b0, 64'h00C0FFEE);
        nf++;
        wait_frames(nf, "wait_post_rst");
        $display("frame after reset bits=%0d", rx_n);
        tick;

        // CLK_DIV=4 header only: every bit held exactly 4 cycles.
        f = build_frame(6'h2D, 1'b0, 0, 1'b0, 64'h0);
        pid = 6'h2D;
        tx_resp = 1'b0;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        cnt = 0;
        while (lin_busy4 && cnt < 200) begin
            if (cnt < 136) check("div4_sdo", 128'(sdo_comm4), 128'(f.bits[cnt/4]));
            cnt++;
            tick;
        end
        check("div4_busy_cycles", 128'(cnt), 128'(136));
        check("div4_done", 128'(comm_tx_done4), 128'(1));
        check("div4_header", 128'(frame_header_out4), 128'(f.hdr));
        $display("frame clk_div=4 busy_cycles=%0d", cnt);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
